seq_divider: RTL

Multicycle signed 32-bit divider that sits directly upstream of the Hi/Lo register pair in the multicycle CPU datapath. It takes the two operands selected by the divider operand muxes (register A/B or MDR), runs a 32-iteration restoring division on operand magnitudes, and produces MIPS `div` results: quotient to `lo`, remainder to `hi`. It also flags divide-by-zero to the control unit, which raises the exception. The control unit starts it and waits for `done`, then writes Hi/Lo.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_div_step.sv | 28 ++
 rtl/seq_divider.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the multicycle signed divider.
package seq_divider_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dmag,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH+1:0] w_shift_rem;
  logic [WIDTH+1:0] w_trial;

  // One guard bit above the shifted remainder keeps the trial sign exact.
  assign w_shift_rem = {i_rem, i_quo[WIDTH-1]};
  assign w_trial     = w_shift_rem - {2'b00, i_dmag};

  always_comb begin
    o_rem = w_shift_rem[WIDTH:0];
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH+1]) begin
      o_rem = w_trial[WIDTH:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider feeding Hi/Lo: quotient to lo, remainder to hi.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_state_nxt;

  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dmag;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_dvs_zero;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  assign w_dvs_zero = (divisor == '0);
  assign w_dvd_mag  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dmag (r_dmag),
    .o_rem  (w_step_rem),
    .o_quo  (w_step_quo)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_dvs_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = FIX;
        end
      end
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next-state decode so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN) || (w_state_nxt == FIX);
      r_done <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_dmag     <= '0;
      r_cnt      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (w_dvs_zero) begin
              r_div_zero <= 1'b1;
            end else begin
              r_quo      <= w_dvd_mag;
              r_dmag     <= w_dvs_mag;
              r_rem      <= '0;
              r_cnt      <= '0;
              r_sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_sign_r   <= dividend[WIDTH-1];
              r_div_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          r_lo <= r_sign_q ? (~r_quo + 1'b1) : r_quo;
          r_hi <= r_sign_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
